// File: rtl/ast_arb_pkg.sv
// Shared types and the round-robin search used by the packet arbiter.
package ast_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int MAX_IN    = 16;
    localparam int MAX_IDX_W = 4;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // Scan ptr, ptr+1, ... wrapping at n; candidates stay below n while ptr < n.
    function automatic pick_t rr_pick(input logic [MAX_IN-1:0]    req,
                                      input logic [MAX_IDX_W-1:0] ptr,
                                      input int                   n);
        pick_t               p;
        int                  cand;
        logic [MAX_IDX_W-1:0] c4;
        p = '0;
        for (int k = 0; k < MAX_IN; k++) begin
            if (k < n) begin
                cand = int'(ptr) + k;
                if (cand >= n) cand = cand - n;
                c4 = cand[MAX_IDX_W-1:0];
                if (!p.found && req[c4]) begin
                    p.found = 1'b1;
                    p.idx   = c4;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: request vector plus pointer to one-hot and binary grant.
module rr_arbiter
    import ast_arb_pkg::*;
#(
    parameter  int N_IN  = 4,
    localparam int IDX_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_IN-1:0]  o_gnt_oh,
    output logic [IDX_W-1:0] o_gnt_idx
);

    pick_t w_pick;

    always_comb begin
        w_pick    = rr_pick(MAX_IN'(i_req), MAX_IDX_W'(i_ptr), N_IN);
        o_gnt_idx = IDX_W'(w_pick.idx);
        o_gnt_oh  = w_pick.found ? (N_IN'(1) << w_pick.idx) : '0;
    end

endmodule

// File: rtl/ast_packet_arbiter.sv
// Packet-granular round-robin merge of N_IN Avalon-ST sources onto one stream;
// the winning source index rides on the output channel field.
module ast_packet_arbiter
    import ast_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int EMPTY_W   = 1,
    parameter int CHANNEL_W = 2,
    parameter int N_IN      = 4
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [N_IN*DATA_W-1:0]    in_ast_data,
    input  logic [N_IN-1:0]           in_ast_startofpacket,
    input  logic [N_IN-1:0]           in_ast_endofpacket,
    input  logic [N_IN-1:0]           in_ast_valid,
    input  logic [N_IN*EMPTY_W-1:0]   in_ast_empty,
    output logic [N_IN-1:0]           in_ast_ready,
    output logic [DATA_W-1:0]         out_ast_data,
    output logic                      out_ast_startofpacket,
    output logic                      out_ast_endofpacket,
    output logic                      out_ast_valid,
    output logic [EMPTY_W-1:0]        out_ast_empty,
    output logic [CHANNEL_W-1:0]      out_ast_channel,
    input  logic                      out_ast_ready,
    output logic                      drop_o
);

    localparam int IDX_W = $clog2(N_IN);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0] r_grant, w_grant_nxt;
    logic [N_IN-1:0]  w_req, w_oop, w_gnt_oh;
    logic [IDX_W-1:0] w_win_idx;

    assign w_req = in_ast_valid & in_ast_startofpacket;
    assign w_oop = in_ast_valid & ~in_ast_startofpacket;

    rr_arbiter #(.N_IN(N_IN)) u_rr (
        .i_req     (w_req),
        .i_ptr     (r_rr_ptr),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_idx (w_win_idx)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_grant  <= w_grant_nxt;
        end
    end

    // Payload fields follow the grant unconditionally; only valid is state-qualified.
    assign out_ast_data          = in_ast_data[32'(r_grant)*DATA_W +: DATA_W];
    assign out_ast_empty         = in_ast_empty[32'(r_grant)*EMPTY_W +: EMPTY_W];
    assign out_ast_startofpacket = in_ast_startofpacket[r_grant];
    assign out_ast_endofpacket   = in_ast_endofpacket[r_grant];
    assign out_ast_channel       = CHANNEL_W'(r_grant);

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_grant_nxt   = r_grant;
        out_ast_valid = 1'b0;
        in_ast_ready  = '0;
        drop_o        = 1'b0;
        case (r_state)
            IDLE: begin
                // Discards are combinational, so hold them off while reset is asserted.
                in_ast_ready = w_oop & {N_IN{arst_n}};
                drop_o       = arst_n & (|w_oop);
                if (|w_gnt_oh) begin
                    w_grant_nxt = w_win_idx;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                out_ast_valid         = in_ast_valid[r_grant];
                in_ast_ready[r_grant] = out_ast_ready;
                if (in_ast_valid[r_grant] && out_ast_ready && in_ast_endofpacket[r_grant]) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = (r_grant == IDX_W'(N_IN - 1)) ? '0 : r_grant + 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Directed bench for ast_packet_arbiter: a 4-source instance driven from per-source
// beat queues, plus a 3-source instance exercising pointer wrap.
module tb_ast_packet_arbiter;

    logic        clk;
    logic        arst_n;
    logic [31:0] in_data;
    logic [3:0]  in_sop, in_eop, in_valid, in_empty, in_ready;
    logic [7:0]  out_data;
    logic        out_sop, out_eop, out_valid, out_ready, drop;
    logic [0:0]  out_empty;
    logic [1:0]  out_ch;

    logic        arst3_n;
    logic [23:0] d3_data;
    logic [2:0]  d3_sop, d3_eop, d3_valid, d3_empty, d3_ready;
    logic [7:0]  o3_data;
    logic        o3_sop, o3_eop, o3_valid, o3_ready, o3_drop;
    logic [0:0]  o3_empty;
    logic [1:0]  o3_ch;

    int n_checks = 0;
    int n_errors = 0;

    ast_packet_arbiter #(.DATA_W(8), .EMPTY_W(1), .CHANNEL_W(2), .N_IN(4)) dut (
        .clk                   (clk),
        .arst_n                (arst_n),
        .in_ast_data           (in_data),
        .in_ast_startofpacket  (in_sop),
        .in_ast_endofpacket    (in_eop),
        .in_ast_valid          (in_valid),
        .in_ast_empty          (in_empty),
        .in_ast_ready          (in_ready),
        .out_ast_data          (out_data),
        .out_ast_startofpacket (out_sop),
        .out_ast_endofpacket   (out_eop),
        .out_ast_valid         (out_valid),
        .out_ast_empty         (out_empty),
        .out_ast_channel       (out_ch),
        .out_ast_ready         (out_ready),
        .drop_o                (drop)
    );

    ast_packet_arbiter #(.DATA_W(8), .EMPTY_W(1), .CHANNEL_W(2), .N_IN(3)) dut3 (
        .clk                   (clk),
        .arst_n                (arst3_n),
        .in_ast_data           (d3_data),
        .in_ast_startofpacket  (d3_sop),
        .in_ast_endofpacket    (d3_eop),
        .in_ast_valid          (d3_valid),
        .in_ast_empty          (d3_empty),
        .in_ast_ready          (d3_ready),
        .out_ast_data          (o3_data),
        .out_ast_startofpacket (o3_sop),
        .out_ast_endofpacket   (o3_eop),
        .out_ast_valid         (o3_valid),
        .out_ast_empty         (o3_empty),
        .out_ast_channel       (o3_ch),
        .out_ast_ready         (o3_ready),
        .drop_o                (o3_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Per-source beat queues and captured output transfers
    logic [7:0] q_data [4][16];
    logic       q_sop  [4][16];
    logic       q_eop  [4][16];
    int         q_len  [4];
    int         q_pos  [4];
    int         cyc;
    int         log_ch[$], log_data[$], log_cyc[$];

    logic       s_valid, s_sop, s_eop, s_drop, s_empty;
    logic [7:0] s_data;
    logic [1:0] s_ch;
    logic [3:0] s_ready;

    logic [7:0] e2_data [10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
    int         e2_ch   [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int         e2_cyc  [10] = '{1, 2, 4, 5, 7, 8, 10, 11, 13, 14};
    logic       bp_rdy  [5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] bp_data [5]  = '{8'hB0, 8'hB1, 8'hB1, 8'hB1, 8'hB2};
    int         ch3[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic clear_q();
        for (int s = 0; s < 4; s++) begin
            q_len[s] = 0;
            q_pos[s] = 0;
        end
        log_ch.delete();
        log_data.delete();
        log_cyc.delete();
        cyc = 0;
    endtask

    task automatic add_beat(input int s, input logic [7:0] d, input logic sop, input logic eop);
        q_data[s][q_len[s]] = d;
        q_sop[s][q_len[s]]  = sop;
        q_eop[s][q_len[s]]  = eop;
        q_len[s]++;
    endtask

    task automatic add_pkt(input int s, input int len, input logic [7:0] base);
        for (int k = 0; k < len; k++)
            add_beat(s, 8'(base + k), k == 0, k == len - 1);
    endtask

    task automatic drive();
        for (int s = 0; s < 4; s++) begin
            if (q_pos[s] < q_len[s]) begin
                in_valid[s]       = 1'b1;
                in_data[s*8 +: 8] = q_data[s][q_pos[s]];
                in_sop[s]         = q_sop[s][q_pos[s]];
                in_eop[s]         = q_eop[s][q_pos[s]];
            end else begin
                in_valid[s]       = 1'b0;
                in_data[s*8 +: 8] = 8'h00;
                in_sop[s]         = 1'b0;
                in_eop[s]         = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
        #1;
        s_valid = out_valid; s_data = out_data; s_ch = out_ch; s_sop = out_sop;
        s_eop = out_eop; s_ready = in_ready; s_drop = drop; s_empty = out_empty[0];
        if (out_valid && out_ready) begin
            log_ch.push_back(int'(out_ch));
            log_data.push_back(int'(out_data));
            log_cyc.push_back(cyc);
        end
        for (int s = 0; s < 4; s++)
            if (in_valid[s] && in_ready[s]) q_pos[s]++;
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        arst_n = 1'b1; arst3_n = 1'b1; out_ready = 1'b1;
        in_data = '0; in_sop = '0; in_eop = '0; in_valid = '0; in_empty = 4'b0100;
        d3_data = {8'd2, 8'd1, 8'd0}; d3_sop = 3'b111; d3_eop = 3'b111;
        d3_valid = 3'b111; d3_empty = 3'b010; o3_ready = 1'b1;
        clear_q();
        #1;
        arst_n = 1'b0; arst3_n = 1'b0;
        // Reset with an out-of-packet beat pending: nothing may be accepted or dropped
        in_valid = 4'b0010;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 0);
        check("rst_drop", drop, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_q(); drive(); arst_n = 1'b1;
        @(posedge clk);

        // Single 4-beat packet on source 2
        clear_q(); add_pkt(2, 4, 8'h20);
        tick();
        check("t1_idle_valid", s_valid, 0);
        check("t1_idle_ready", s_ready, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_valid", s_valid, 1);
            check("t1_ch", s_ch, 2);
            check("t1_data", s_data, 8'h20 + k);
            check("t1_ready", s_ready, 4'b0100);
            check("t1_sop", s_sop, k == 0);
            check("t1_eop", s_eop, k == 3);
            check("t1_empty", s_empty, 1);
        end
        check("t1_count", log_data.size(), 4);

        // Pointer now 3: with sources 2 and 3 requesting, 3 must win first
        clear_q(); add_pkt(2, 1, 8'h2A); add_pkt(3, 1, 8'h3A);
        repeat (4) tick();
        check("t1b_count", log_data.size(), 2);
        if (log_data.size() == 2) begin
            check("t1b_first", log_data[0], 8'h3A);
            check("t1b_second", log_data[1], 8'h2A);
        end

        // Out-of-packet beat on source 1 dropped while source 0 is granted
        clear_q(); add_beat(1, 8'h1F, 1'b0, 1'b0); add_pkt(0, 1, 8'h05);
        tick();
        check("t4_ready", s_ready, 4'b0010);
        check("t4_drop", s_drop, 1);
        check("t4_idle_valid", s_valid, 0);
        tick();
        check("t4_valid", s_valid, 1);
        check("t4_ch", s_ch, 0);
        check("t4_data", s_data, 8'h05);
        check("t4_ready_busy", s_ready, 4'b0001);
        check("t4_nodrop", s_drop, 0);
        tick();
        check("t4_after_valid", s_valid, 0);
        check("t4_count", log_data.size(), 1);

        // Backpressure on source 1: ready 1,0,0,1,1 during BUSY
        clear_q(); add_pkt(1, 3, 8'hB0);
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            out_ready = bp_rdy[k];
            tick();
            check("t3_valid", s_valid, 1);
            check("t3_ready", s_ready, {2'b00, bp_rdy[k], 1'b0});
            check("t3_data", s_data, bp_data[k]);
        end
        out_ready = 1'b1;
        check("t3_count", log_data.size(), 3);
        for (int k = 0; k < log_data.size() && k < 3; k++)
            check("t3_seq", log_data[k], 8'hB0 + k);

        // Reset in the middle of a 5-beat packet on source 3
        clear_q(); add_pkt(3, 5, 8'hC0);
        repeat (3) tick();
        @(negedge clk);
        drive();
        #1;
        check("t5_pre_valid", out_valid, 1);
        check("t5_pre_data", out_data, 8'hC2);
        arst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        clear_q(); drive(); arst_n = 1'b1;
        @(posedge clk);

        // All sources request together from reset; source 0 has a second packet
        clear_q();
        add_pkt(0, 2, 8'h00); add_pkt(0, 2, 8'h02);
        add_pkt(1, 2, 8'h10); add_pkt(2, 2, 8'h20); add_pkt(3, 2, 8'h30);
        repeat (16) tick();
        check("t2_count", log_data.size(), 10);
        for (int i = 0; i < log_data.size() && i < 10; i++) begin
            check("t2_data", log_data[i], e2_data[i]);
            check("t2_ch", log_ch[i], e2_ch[i]);
            check("t2_cyc", log_cyc[i], e2_cyc[i]);
        end

        // Three sources, single-beat packets: channel must wrap 2 -> 0
        @(negedge clk);
        arst3_n = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            #1;
            if (o3_valid) begin
                ch3.push_back(int'(o3_ch));
                check("t6_data", o3_data, {6'd0, o3_ch});
                check("t6_sopeop", {o3_sop, o3_eop}, 2'b11);
                check("t6_ready", d3_ready, 3'(1) << o3_ch);
                check("t6_empty", o3_empty, o3_ch == 2'd1);
            end
        end
        check("t6_count", ch3.size(), 9);
        for (int i = 0; i < ch3.size() && i < 9; i++)
            check("t6_ch", ch3[i], i % 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
